// File: rtl/hand_deal_ctrl.sv
// hand_deal_ctrl: deals one hand of unique cards from a valid/ready deck source into the
// hand memory, then waits (bounded) for the memory to report the hand as full.
module hand_deal_ctrl #(
    parameter int unsigned HAND_SIZE    = 5,
    parameter int unsigned CARD_W       = 6,
    parameter int unsigned FULL_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_card_valid,
    input  logic [CARD_W-1:0] i_card_data,
    output logic              o_card_ready,
    input  logic              i_hand_full,
    output logic              o_mem_clr,
    output logic              o_we,
    output logic [2:0]        o_waddr,
    output logic [CARD_W-1:0] o_card_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_dup_seen,
    output logic              o_err
);

    localparam int unsigned CntW = $clog2(HAND_SIZE + 1);
    localparam int unsigned ToW  = $clog2(FULL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StDeal,
        StWaitFull,
        StDone,
        StError
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [CntW-1:0]     r_count;
    logic [ToW-1:0]      r_to_cnt;
    logic [CARD_W-1:0]   r_dealt [HAND_SIZE];
    logic [HAND_SIZE-1:0] r_dealt_vld;
    logic                r_we;
    logic [2:0]          r_waddr;
    logic [CARD_W-1:0]   r_card_in;
    logic                r_done;
    logic                r_dup;
    logic                r_mem_clr;
    logic                w_xfer;
    logic                w_match;

    assign o_card_ready = (r_state == StDeal);
    assign o_busy       = (r_state == StClear) || (r_state == StDeal) || (r_state == StWaitFull);
    assign o_err        = (r_state == StError);
    assign o_we         = r_we;
    assign o_waddr      = r_waddr;
    assign o_card_in    = r_card_in;
    assign o_done       = r_done;
    assign o_dup_seen   = r_dup;
    assign o_mem_clr    = r_mem_clr;

    assign w_xfer = i_card_valid && o_card_ready;

    // Duplicate check of the offered card against every slot already dealt this hand.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < HAND_SIZE; i++) begin
            if (r_dealt_vld[i] && (r_dealt[i] == i_card_data)) begin
                w_match = 1'b1;
            end
        end
    end

    // Next-state decode; abort overrides everything, including start and a same-cycle transfer.
    always_comb begin
        w_state_d = r_state;
        if (i_abort) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (i_start) w_state_d = StClear;
                StClear: w_state_d = StDeal;
                StDeal: begin
                    if (w_xfer && !w_match && (r_count == CntW'(HAND_SIZE - 1))) begin
                        w_state_d = StWaitFull;
                    end
                end
                StWaitFull: begin
                    // hand_full is only trusted once the final write has left the port
                    if (!r_we && i_hand_full) begin
                        w_state_d = StDone;
                    end else if (r_to_cnt == ToW'(FULL_TIMEOUT - 1)) begin
                        w_state_d = StError;
                    end
                end
                StDone:  w_state_d = StIdle;
                StError: if (i_start) w_state_d = StClear;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // State register, counters, dealt-card registers and registered memory-port outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_to_cnt    <= '0;
            r_dealt_vld <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_card_in   <= '0;
            r_done      <= 1'b0;
            r_dup       <= 1'b0;
            r_mem_clr   <= 1'b0;
            for (int i = 0; i < HAND_SIZE; i++) begin
                r_dealt[i] <= '0;
            end
        end else begin
            r_state   <= w_state_d;
            r_we      <= 1'b0;
            r_dup     <= 1'b0;
            r_done    <= (w_state_d == StDone);
            r_mem_clr <= (w_state_d == StClear);
            if (i_abort) begin
                r_count  <= '0;
                r_to_cnt <= '0;
            end else begin
                case (r_state)
                    StClear: begin
                        r_count     <= '0;
                        r_to_cnt    <= '0;
                        r_dealt_vld <= '0;
                        for (int i = 0; i < HAND_SIZE; i++) begin
                            r_dealt[i] <= '0;
                        end
                    end
                    StDeal: begin
                        if (w_xfer && w_match) begin
                            r_dup <= 1'b1;
                        end else if (w_xfer) begin
                            for (int i = 0; i < HAND_SIZE; i++) begin
                                if (CntW'(i) == r_count) begin
                                    r_dealt[i]     <= i_card_data;
                                    r_dealt_vld[i] <= 1'b1;
                                end
                            end
                            r_we      <= 1'b1;
                            r_waddr   <= 3'(r_count);
                            r_card_in <= i_card_data;
                            r_count   <= r_count + 1'b1;
                        end
                    end
                    StWaitFull: r_to_cnt <= r_to_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
